// File: rtl/apb4_slave_regfile_if.sv
// APB4 bus bundle between a requester and the register-file slave.
// Signal names follow the APB4 protocol; clock and reset stay outside the bundle.
interface apb4_slave_regfile_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_WIDTH-1:0]     PADDR;
    logic [DATA_WIDTH-1:0]     PWDATA;
    logic [DATA_WIDTH/8-1:0]   PSTRB;
    logic [DATA_WIDTH-1:0]     PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb4_slave_regfile.sv
// APB4 register file: read-only ID at index 0, byte-strobed R/W registers above it,
// programmable access-phase wait states and PSLVERR on bad or read-only accesses.
module apb4_slave_regfile #(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                            PCLK,
    input  logic                            PRESET,
    apb4_slave_regfile_if.slave             bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0]  regs_o
);
    localparam int                    NB       = DATA_WIDTH / 8;
    localparam int                    AB       = $clog2(NB);
    localparam logic [3:0]            WS       = 4'(WAIT_STATES);
    localparam logic [DATA_WIDTH-1:0] ID_W     = DATA_WIDTH'(ID_VALUE);
    localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'((1 << AB) - 1);
    localparam logic [ADDR_WIDTH:0]   NREG     = (ADDR_WIDTH + 1)'(NUM_REGS);

    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS-1:1];

    logic                  w_access;
    logic                  w_ready;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_idx    = bus.PADDR >> AB;
    assign w_access = bus.PSEL & bus.PENABLE;
    assign w_ready  = w_access & (r_cnt == WS) & ~PRESET;
    // Out-of-range index, sub-word offset, or any write to the ID register.
    assign w_err    = ({1'b0, w_idx} >= NREG)
                    | (|(bus.PADDR & OFS_MASK))
                    | (bus.PWRITE & (w_idx == '0));

    // Wait counter restarts on every completion so back-to-back transfers each pay the full wait.
    always_ff @(posedge PCLK) begin
        if (PRESET || !bus.PSEL || w_ready) begin
            r_cnt <= '0;
        end else if (w_access) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_ready && bus.PWRITE && !w_err) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_idx == ADDR_WIDTH'(i) && bus.PSTRB[b]) begin
                        r_regs[i][8*b +: 8] <= bus.PWDATA[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_ready && !bus.PWRITE && !w_err) begin
            if (w_idx == '0) begin
                w_rdata = ID_W;
            end
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_idx == ADDR_WIDTH'(i)) begin
                    w_rdata = r_regs[i];
                end
            end
        end
    end

    assign bus.PRDATA  = w_rdata;
    assign bus.PREADY  = w_ready;
    assign bus.PSLVERR = w_ready & w_err;

    assign regs_o[DATA_WIDTH-1:0] = ID_W;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs_o
        assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end
endmodule

// File: doc/apb4_slave_regfile.md
APB4_SLAVE_REGFILE -- requirements
Module: apb4_slave_regfile

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, APB byte-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data width in bits (8, 16, 32 or 64).
REQ-003 The block SHALL have parameter NUM_REGS, default 8, register count, 2 to 2^(ADDR_WIDTH-AB), where AB = log2(DATA_WIDTH/8).
REQ-004 The block SHALL have parameter WAIT_STATES, default 0, access-phase wait cycles inserted before PREADY, 0 to 15.
REQ-005 The block SHALL have parameter ID_VALUE, default 32'hA9B0_0001, read-only contents of register 0 (zero-extended or truncated to DATA_WIDTH).
REQ-006 The block SHALL have one clock and one synchronous, active-high reset.
REQ-007 The block SHALL have these ports:
- PCLK  input  1  clock; all state updates on the rising edge.
- PRESET  input  1  synchronous active-high reset.
- PSEL  input  1  slave select.
- PENABLE  input  1  access phase.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_WIDTH  byte address.
- PWDATA  input  DATA_WIDTH  write data.
- PSTRB  input  DATA_WIDTH/8  byte write strobes.
- PRDATA  output  DATA_WIDTH  read data.
- PREADY  output  1  transfer complete.
- PSLVERR  output  1  transfer error.
- regs_o  output  NUM_REGS*DATA_WIDTH  flattened register contents; register i at bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-008 The block SHALL decode the register index as idx = PADDR[ADDR_WIDTH-1:AB].
REQ-009 An access cycle SHALL be any cycle with PSEL=1 and PENABLE=1; PENABLE without PSEL SHALL be ignored.
REQ-010 A wait counter cnt of 4 bits SHALL increment in each access cycle with PREADY=0.
REQ-011 cnt SHALL clear on the cycle after PREADY=1 and in any cycle with PSEL=0.
REQ-012 PREADY SHALL be combinational: 1 iff access cycle and cnt == WAIT_STATES and PRESET=0; WAIT_STATES=0 gives zero-wait transfers.
REQ-013 Back-to-back transfers SHALL each incur the full WAIT_STATES, because cnt restarts from 0.
REQ-014 Error condition err SHALL be 1 if idx >= NUM_REGS, or PADDR[AB-1:0] != 0, or (PWRITE=1 and idx == 0).
REQ-015 PSLVERR SHALL equal PREADY & err and SHALL be 0 in all other cycles.
REQ-016 On a write with PREADY=1 and err=0, register idx SHALL update at the rising edge, byte lane b taking PWDATA[8b+7:8b] only where PSTRB[b]=1.
REQ-017 An error write SHALL modify no register.
REQ-018 A write with PSTRB=0 and no error SHALL complete with PSLVERR=0 and no change.
REQ-019 On a read with PREADY=1, PRDATA SHALL be ID_VALUE for idx 0, register idx for other valid idx, and 0 on error.
REQ-020 PRDATA SHALL be 0 whenever PREADY=0.
REQ-021 If PSEL drops before PREADY (abort), cnt SHALL clear and no register SHALL change.
REQ-022 regs_o SHALL reflect register state registered at the most recent edge; the register-0 slice SHALL always equal ID_VALUE.

Reset
REQ-023 While PRESET=1, registers 1..NUM_REGS-1 SHALL load 0 at each edge and cnt SHALL load 0.
REQ-024 While PRESET=1, PREADY, PSLVERR and PRDATA SHALL be forced to 0.
REQ-025 Reset asserted mid-wait SHALL discard the pending transfer with no register update; the first access after release SHALL start with cnt=0.

Verification (ADDR_WIDTH=8, DATA_WIDTH=32, NUM_REGS=8, WAIT_STATES=2)
REQ-026 Write 0x08 = 0xA5A5A5A5 with PSTRB=4'hF, then read 0x08 -> each PREADY rises in the 3rd access cycle; read returns 0xA5A5A5A5 with PSLVERR=0.
REQ-027 After REQ-026, write 0x08 = 0x11223344 with PSTRB=4'b0101 -> read returns 0xA522A544.
REQ-028 Read 0x00 -> 0xA9B0_0001; write 0x00 = 0xFFFFFFFF -> PSLVERR=1 with PREADY; subsequent read of 0x00 is still 0xA9B0_0001.
REQ-029 Read 0x20 (idx 8) and write 0x06 (misaligned) -> PSLVERR=1, PRDATA=0, all regs_o unchanged.
REQ-030 Write 0x04 = 0xDEADBEEF with PRESET pulsed high in the 2nd access cycle -> PREADY never asserts; register 1 reads 0 after reset; the next transfer waits the full 2 cycles.
REQ-031 Run with WAIT_STATES=0 and back-to-back write then read of 0x1C -> PREADY=1 in the first access cycle of each transfer; read returns the written data.
